// File: rtl/booth_seq_multiplier_if.sv
// ============================================================================
//  Module      : booth_seq_multiplier_if
//  Description : Request/response bundle for the sequential Booth multiplier.
//                master : requester (FC fetch logic / testbench)
//                slave  : booth_seq_multiplier
//  Signals     : start, sgn, M[N], R[N], acc_en, acc_clr  (master -> slave)
//                ready, done, mulResult[2N], acc_out[ACC_W] (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_seq_multiplier_if #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8
);
    logic               start;
    logic               sgn;
    logic [N-1:0]       M;
    logic [N-1:0]       R;
    logic               acc_en;
    logic               acc_clr;
    logic               ready;
    logic               done;
    logic [2*N-1:0]     mulResult;
    logic [ACC_W-1:0]   acc_out;

    modport master (
        output start, sgn, M, R, acc_en, acc_clr,
        input  ready, done, mulResult, acc_out
    );

    modport slave (
        input  start, sgn, M, R, acc_en, acc_clr,
        output ready, done, mulResult, acc_out
    );
endinterface

`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
// ============================================================================
//  Module      : booth_seq_multiplier
//  Description : Iterative radix-4 Booth multiplier, signed or unsigned per
//                operation, with start/ready/done handshake and an optional
//                multiply-accumulate register (enabled by defining the macro
//                BOOTH_ACC_EN; without it acc_out is tied to 0).
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - booth_seq_multiplier_if.slave (start, sgn, M, R,
//                         acc_en, acc_clr in; ready, done, mulResult,
//                         acc_out out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_seq_multiplier #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    booth_seq_multiplier_if.slave   bus
);

    // Internal width: at least one spare bit so unsigned operands stay
    // positive when treated as signed, rounded up to even for radix-4.
    localparam int c_W    = (N % 2 == 0) ? N + 2 : N + 1;
    localparam int c_ITER = c_W / 2;
    localparam int c_CW   = $clog2(c_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_ready;
    logic               w_done;
    logic               w_capture;
    logic               w_finish;

    logic [c_CW-1:0]    r_cnt;
    logic [c_W-1:0]     r_m;
    // {upper W bits, multiplier W bits, guard bit}
    logic [2*c_W:0]     r_p;
    logic [2*N-1:0]     r_mul_result;

    logic [c_W-1:0]     w_m_ext;
    logic [c_W-1:0]     w_r_ext;
    logic [c_W+1:0]     w_m_wide;
    logic [c_W+1:0]     w_pp;
    logic [c_W+1:0]     w_sum;
    logic [2*c_W:0]     w_p_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_done       = 1'b1;
                w_state_next = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_capture = w_ready & bus.start;
    assign w_finish  = (r_state == S_RUN) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Booth datapath
    // ------------------------------------------------------------------
    assign w_m_ext  = {{(c_W-N){bus.sgn & bus.M[N-1]}}, bus.M};
    assign w_r_ext  = {{(c_W-N){bus.sgn & bus.R[N-1]}}, bus.R};
    assign w_m_wide = {{2{r_m[c_W-1]}}, r_m};

    always_comb begin
        w_pp = '0;
        case (r_p[2:0])
            3'b001, 3'b010: w_pp = w_m_wide;
            3'b011:         w_pp = w_m_wide << 1;
            3'b100:         w_pp = -(w_m_wide << 1);
            3'b101, 3'b110: w_pp = -w_m_wide;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum = {{2{r_p[2*c_W]}}, r_p[2*c_W:c_W+1]} + w_pp;

    // Arithmetic shift right by 2: the two bits dropped off the top of the
    // sum are sign copies, so concatenation is enough.
    assign w_p_next = {w_sum, r_p[c_W:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_m          <= '0;
            r_p          <= '0;
            r_mul_result <= '0;
        end else if (w_capture) begin
            r_cnt <= c_CW'(c_ITER - 1);
            r_m   <= w_m_ext;
            r_p   <= {{c_W{1'b0}}, w_r_ext, 1'b0};
        end else if (r_state == S_RUN) begin
            r_p <= w_p_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
            if (w_finish) begin
                r_mul_result <= w_p_next[2*N:1];
            end
        end
    end

    assign bus.ready     = w_ready;
    assign bus.done      = w_done;
    assign bus.mulResult = r_mul_result;

    // ------------------------------------------------------------------
    // Optional multiply-accumulate
    // ------------------------------------------------------------------
`ifdef BOOTH_ACC_EN
    logic               r_sgn;
    logic               r_acc_en;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_prod_ext;

    if (ACC_W > 2*N) begin : g_prod_ext_wide
        assign w_prod_ext = {{(ACC_W-2*N){r_sgn & w_p_next[2*N]}}, w_p_next[2*N:1]};
    end else begin : g_prod_ext_exact
        assign w_prod_ext = w_p_next[2*N:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn    <= 1'b0;
            r_acc_en <= 1'b0;
        end else if (w_capture) begin
            r_sgn    <= bus.sgn;
            r_acc_en <= bus.acc_en;
        end
    end

    // Clear is only possible while ready, accumulate only on the RUN->DONE
    // edge, so the two can never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_ready && bus.acc_clr) begin
            r_acc <= '0;
        end else if (w_finish && r_acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign bus.acc_out = r_acc;
`else
    assign bus.acc_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
// ============================================================================
//  Module      : tb_booth_seq_multiplier
//  Description : Directed self-checking bench for booth_seq_multiplier with
//                N=5, ACC_W=18. Accumulator expectations apply when
//                BOOTH_ACC_EN is defined; otherwise acc_out must stay 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_multiplier;

    localparam int N     = 5;
    localparam int ACC_W = 18;
    localparam int ITER  = 3;
`ifdef BOOTH_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    booth_seq_multiplier_if #(.N(N), .ACC_W(ACC_W)) bus ();

    booth_seq_multiplier #(.N(N), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation from IDLE; operands are scrambled after capture
    // to show they are only sampled at the capture edge.
    task automatic op(input string tag, input logic s, input logic [4:0] m,
                      input logic [4:0] r, input logic ae, input logic clr,
                      input logic [9:0] exp_p, input logic [17:0] exp_acc);
        int edges;
        bus.sgn = s; bus.M = m; bus.R = r; bus.acc_en = ae;
        bus.acc_clr = clr; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.acc_clr = 1'b0;
        bus.sgn = ~s; bus.M = ~m; bus.R = ~r; bus.acc_en = ~ae;
        chk({tag, "_busy"}, bus.ready, 1'b0);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        chk({tag, "_lat"}, edges, ITER);
        chk({tag, "_prod"}, bus.mulResult, exp_p);
        chk({tag, "_rdy"}, bus.ready, 1'b1);
        chk({tag, "_acc"}, bus.acc_out, ACC_ON ? exp_acc : 18'd0);
        tick();
        chk({tag, "_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        logic [4:0]  mv, rv;
        logic [9:0]  ep;
        logic [17:0] ea;
        int          a, b, extra, ndone, edges;

        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sgn = 1'b0; bus.M = '0; bus.R = '0;
        bus.acc_en = 1'b0; bus.acc_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_done",  bus.done,  1'b0);
        chk("rst_prod",  bus.mulResult, 10'd0);
        chk("rst_acc",   bus.acc_out, 18'd0);
        rst_n = 1'b1;
        tick();

        // Directed products
        op("s7xm3",    1'b1, 5'd7,     5'b11101, 1'b0, 1'b0, 10'h3EB, 18'd0);
        op("sm16sq",   1'b1, 5'b10000, 5'b10000, 1'b0, 1'b0, 10'h100, 18'd0);
        op("u31sq",    1'b0, 5'd31,    5'd31,    1'b0, 1'b0, 10'h3C1, 18'd0);
        op("s0xm1",    1'b1, 5'd0,     5'b11111, 1'b0, 1'b0, 10'h000, 18'd0);
        op("sm16x15",  1'b1, 5'b10000, 5'd15,    1'b0, 1'b0, 10'h310, 18'd0);
        op("u31x1",    1'b0, 5'd31,    5'd1,     1'b0, 1'b0, 10'h01F, 18'd0);

        // start pulsed during RUN is ignored
        bus.sgn = 1'b0; bus.M = 5'd3; bus.R = 5'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.M = 5'd7; bus.R = 5'd7;
        tick();
        bus.start = 1'b0;
        edges = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        chk("ign_lat", edges, 1);
        chk("ign_prod", bus.mulResult, 10'd15);
        extra = 0;
        repeat (8) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        chk("ign_extra_done", extra, 0);
        chk("ign_idle", bus.ready, 1'b1);

        // Reset in the second RUN cycle aborts immediately
        bus.sgn = 1'b1; bus.M = 5'd7; bus.R = 5'b11101; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_done",  bus.done,  1'b0);
        chk("abort_prod",  bus.mulResult, 10'd0);
        chk("abort_acc",   bus.acc_out, 18'd0);
        tick();
        chk("abort_done2", bus.done, 1'b0);
        rst_n = 1'b1;
        tick();
        op("after_abort", 1'b1, 5'd7, 5'b11101, 1'b0, 1'b0, 10'h3EB, 18'd0);

        // Exhaustive back-to-back sweep, signed then unsigned
        for (int s = 1; s >= 0; s--) begin
            extra = 0;
            ndone = 0;
            bus.sgn = s[0]; bus.acc_en = 1'b0;
            bus.M = 5'd0; bus.R = 5'd0; bus.start = 1'b1;
            tick();
            for (int k = 0; k < 1024; k++) begin
                for (int j = 1; j < ITER; j++) begin
                    tick();
                    if (bus.done === 1'b1) extra++;
                end
                tick();
                if (bus.done === 1'b1) ndone++;
                mv = k[9:5];
                rv = k[4:0];
                a = s[0] ? int'($signed(mv)) : int'(mv);
                b = s[0] ? int'($signed(rv)) : int'(rv);
                ep = 10'(a * b);
                chk(s[0] ? "sweep_s" : "sweep_u", {bus.done, bus.mulResult}, {1'b1, ep});
                if (k < 1023) begin
                    bus.M = 5'((k + 1) >> 5);
                    bus.R = 5'(k + 1);
                end else begin
                    bus.start = 1'b0;
                end
                tick();
                if (k == 1023 && bus.done === 1'b1) extra++;
            end
            chk(s[0] ? "sweep_s_extra" : "sweep_u_extra", extra, 0);
            chk(s[0] ? "sweep_s_count" : "sweep_u_count", ndone, 1024);
        end

        // Accumulator
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        chk("clr0", bus.acc_out, 18'd0);
        op("acc12",   1'b0, 5'd3,     5'd4, 1'b1, 1'b0, 10'd12,  18'd12);
        op("acc37",   1'b0, 5'd5,     5'd5, 1'b1, 1'b0, 10'd25,  18'd37);
        op("acc_off", 1'b0, 5'd2,     5'd2, 1'b0, 1'b0, 10'd4,   18'd37);
        op("acc_neg", 1'b1, 5'b11101, 5'd5, 1'b1, 1'b0, 10'h3F1, 18'd22);
        op("clr_start", 1'b0, 5'd1,   5'd1, 1'b1, 1'b1, 10'd1,   18'd1);
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        chk("clr1", bus.acc_out, 18'd0);
        for (int k = 1; k <= 1170; k++) begin
            ea = 18'((225 * k) % 262144);
            op("wrap", 1'b0, 5'd15, 5'd15, 1'b1, 1'b0, 10'd225, ea);
        end
        chk("wrap_final", bus.acc_out, ACC_ON ? 18'd1106 : 18'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
